ws2812_stream_decoder: RTL and testbench

- Receives the single-wire WS2812B-format datastream produced by the LED-matrix driver and decodes it back into 24-bit color words.
- Used as an on-board loopback checker and as the input stage for a chained second face display.
- Measures high- and low-pulse widths with the 40 MHz system clock, classifies bits, assembles words, and reports pixel and frame boundaries and protocol errors.

---
 rtl/ws2812_stream_decoder.sv | 207 ++++++++++++++++++++
 tb/tb_ws2812_stream_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_stream_decoder.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | ws2812_stream_decoder: WS2812B single-wire stream to 24-bit word decoder |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module ws2812_stream_decoder #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_HIGH     = 4,
  parameter int BIT_THRESH   = 24,
  parameter int MAX_HIGH     = 48,
  parameter int RESET_CYCLES = 1500,
  parameter int FRAME_CYCLES = 8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [8:0]  pixel_index,
  output logic        frame_done,
  output logic [8:0]  frame_pixels,
  output logic        bit_error,
  output logic        busy
);

  localparam logic [6:0]  c_min_high   = 7'(MIN_HIGH);
  localparam logic [6:0]  c_bit_thresh = 7'(BIT_THRESH);
  localparam logic [6:0]  c_max_high   = 7'(MAX_HIGH);
  localparam logic [13:0] c_reset_cyc  = 14'(RESET_CYCLES);
  localparam logic [13:0] c_frame_cyc  = 14'(FRAME_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HIGH   = 2'd1,
    S_LOW    = 2'd2,
    S_RESYNC = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ds_d;
  logic                   w_ds;
  logic                   w_rise;
  logic                   w_fall;

  state_t      r_state,        w_state_n;
  logic [6:0]  r_hcnt,         w_hcnt_n;
  logic [13:0] r_lcnt,         w_lcnt_n;
  logic [4:0]  r_bitcnt,       w_bitcnt_n;
  logic [22:0] r_shift,        w_shift_n;
  logic [23:0] r_pixel_data,   w_pixel_data_n;
  logic        r_pixel_valid,  w_pixel_valid_n;
  logic [8:0]  r_pixel_index,  w_pixel_index_n;
  logic        r_frame_done,   w_frame_done_n;
  logic [8:0]  r_frame_pixels, w_frame_pixels_n;
  logic        r_bit_error,    w_bit_error_n;
  logic        w_bit;
  logic [6:0]  w_hcnt_inc;
  logic [13:0] w_lcnt_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_ds_d <= 1'b0;
    end else begin
      r_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_ds_d <= w_ds;
    end
  end

  assign w_ds   = r_sync[SYNC_STAGES-1];
  assign w_rise = w_ds & ~r_ds_d;
  assign w_fall = ~w_ds & r_ds_d;

  assign w_hcnt_inc = (r_hcnt == 7'h7f)     ? r_hcnt : r_hcnt + 7'd1;
  assign w_lcnt_inc = (r_lcnt == 14'h3fff)  ? r_lcnt : r_lcnt + 14'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_hcnt         <= '0;
      r_lcnt         <= '0;
      r_bitcnt       <= '0;
      r_shift        <= '0;
      r_pixel_data   <= '0;
      r_pixel_valid  <= 1'b0;
      r_pixel_index  <= '0;
      r_frame_done   <= 1'b0;
      r_frame_pixels <= '0;
      r_bit_error    <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_hcnt         <= w_hcnt_n;
      r_lcnt         <= w_lcnt_n;
      r_bitcnt       <= w_bitcnt_n;
      r_shift        <= w_shift_n;
      r_pixel_data   <= w_pixel_data_n;
      r_pixel_valid  <= w_pixel_valid_n;
      r_pixel_index  <= w_pixel_index_n;
      r_frame_done   <= w_frame_done_n;
      r_frame_pixels <= w_frame_pixels_n;
      r_bit_error    <= w_bit_error_n;
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_hcnt_n         = r_hcnt;
    w_lcnt_n         = r_lcnt;
    w_bitcnt_n       = r_bitcnt;
    w_shift_n        = r_shift;
    w_pixel_data_n   = r_pixel_data;
    w_pixel_valid_n  = 1'b0;
    w_pixel_index_n  = r_pixel_index;
    w_frame_done_n   = 1'b0;
    w_frame_pixels_n = r_frame_pixels;
    w_bit_error_n    = r_bit_error;
    w_bit            = (r_hcnt >= c_bit_thresh);

    // Index advances the cycle after the strobe so pixel_index names the word on pixel_valid.
    if (r_pixel_valid) begin
      if (r_pixel_index == 9'd511) begin
        w_bit_error_n = 1'b1;
      end else begin
        w_pixel_index_n = r_pixel_index + 9'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_lcnt_n = w_lcnt_inc;
        if (w_rise) begin
          w_state_n = S_HIGH;
          w_hcnt_n  = 7'd1;
        end else if (r_lcnt == c_frame_cyc && r_pixel_index != 9'd0) begin
          w_frame_done_n   = 1'b1;
          w_frame_pixels_n = r_pixel_index;
          w_pixel_index_n  = 9'd0;
        end
      end

      S_HIGH: begin
        w_hcnt_n = w_hcnt_inc;
        if (w_fall) begin
          if (r_hcnt < c_min_high) begin
            w_bit_error_n = 1'b1;
            w_bitcnt_n    = 5'd0;
            w_lcnt_n      = 14'd0;
            w_state_n     = S_RESYNC;
          end else begin
            w_state_n = S_LOW;
            w_lcnt_n  = 14'd1;
            if (r_bitcnt == 5'd23) begin
              w_pixel_data_n  = {w_bit, r_shift};
              w_pixel_valid_n = 1'b1;
              w_bitcnt_n      = 5'd0;
            end else begin
              w_shift_n[r_bitcnt] = w_bit;
              w_bitcnt_n          = r_bitcnt + 5'd1;
            end
          end
        end else if (r_hcnt >= c_max_high) begin
          w_bit_error_n = 1'b1;
          w_bitcnt_n    = 5'd0;
          w_lcnt_n      = 14'd0;
          w_state_n     = S_RESYNC;
        end
      end

      S_LOW: begin
        w_lcnt_n = w_lcnt_inc;
        if (w_rise) begin
          w_state_n = S_HIGH;
          w_hcnt_n  = 7'd1;
        end else if (r_lcnt == c_reset_cyc) begin
          w_state_n = S_IDLE;
          if (r_bitcnt != 5'd0) begin
            w_bit_error_n = 1'b1;
            w_bitcnt_n    = 5'd0;
          end
        end
      end

      S_RESYNC: begin
        w_lcnt_n = w_ds ? 14'd0 : w_lcnt_inc;
        if (r_lcnt == c_reset_cyc && !w_ds) begin
          w_state_n  = S_IDLE;
          w_bitcnt_n = 5'd0;
        end
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  assign pixel_data   = r_pixel_data;
  assign pixel_valid  = r_pixel_valid;
  assign pixel_index  = r_pixel_index;
  assign frame_done   = r_frame_done;
  assign frame_pixels = r_frame_pixels;
  assign bit_error    = r_bit_error;
  assign busy         = (r_bitcnt != 5'd0) || (r_state == S_HIGH);

endmodule
`default_nettype wire

// File: tb/tb_ws2812_stream_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | tb_ws2812_stream_decoder: directed bench for ws2812_stream_decoder       |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_ws2812_stream_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [8:0]  pixel_index;
  logic        frame_done;
  logic [8:0]  frame_pixels;
  logic        bit_error;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_frame = 0;
  logic [23:0] last_data = '0;
  logic [8:0]  last_index = '0;
  int idx_log [0:127];

  ws2812_stream_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .din          (din),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_index  (pixel_index),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .bit_error    (bit_error),
    .busy         (busy)
  );

  always #12.5 clk = ~clk;

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (n_valid < 128) idx_log[n_valid] = int'(pixel_index);
      last_data  = pixel_data;
      last_index = pixel_index;
      n_valid    = n_valid + 1;
    end
    if (frame_done) n_frame = n_frame + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Driver timing (17/35 for 0, 33/19 for 1) or fast timing (5/3, 25/3).
  task automatic send_bits(input logic [23:0] w, input int nbits, input bit fast);
    for (int i = 0; i < nbits; i++) begin
      if (fast) pulse(w[i] ? 25 : 5, 3);
      else      pulse(w[i] ? 33 : 17, w[i] ? 19 : 35);
    end
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int nv0;
  int bad;

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_data",   32'(pixel_data),   32'h0);
    chk("rst_valid",  32'(pixel_valid),  32'h0);
    chk("rst_index",  32'(pixel_index),  32'h0);
    chk("rst_fpix",   32'(frame_pixels), 32'h0);
    chk("rst_error",  32'(bit_error),    32'h0);
    chk("rst_busy",   32'(busy),         32'h0);

    // Single word with driver timing
    send_bits(24'h00b000, 24, 1'b0);
    idle(20);
    chk("w1_count", 32'(n_valid),    32'd1);
    chk("w1_data",  32'(last_data),  32'h00b000);
    chk("w1_index", 32'(last_index), 32'd0);
    chk("w1_error", 32'(bit_error),  32'h0);
    chk("w1_busy",  32'(busy),       32'h0);
    idle(2000);

    // 64 more words: a few with 2000-cycle gaps, the rest back-to-back-ish
    for (int k = 1; k <= 64; k++) begin
      send_bits(24'(k), 24, 1'b1);
      idle(k < 4 ? 2000 : 40);
    end
    chk("frm_count", 32'(n_valid),     32'd65);
    chk("frm_last",  32'(last_data),   32'd64);
    chk("frm_nofd",  32'(n_frame),     32'd0);
    bad = 0;
    for (int i = 0; i < 65; i++) if (idx_log[i] != i) bad++;
    chk("frm_idxseq", 32'(bad), 32'd0);
    idle(8100);
    chk("frm_done",   32'(n_frame),      32'd1);
    chk("frm_pixels", 32'(frame_pixels), 32'd65);
    chk("frm_index",  32'(pixel_index),  32'd0);
    idle(1000);
    chk("frm_once",   32'(n_frame),      32'd1);

    // 23-cycle high is a 0, 24-cycle high is a 1
    nv0 = n_valid;
    pulse(23, 35);
    pulse(24, 19);
    send_bits(24'h0, 22, 1'b0);
    idle(20);
    chk("thr_count", 32'(n_valid - nv0), 32'd1);
    chk("thr_data",  32'(last_data),     32'h000002);
    chk("thr_index", 32'(last_index),    32'd0);
    chk("thr_error", 32'(bit_error),     32'h0);

    // 3-cycle glitch, then pulses ignored until a 1500-cycle low
    nv0 = n_valid;
    send_bits(24'h000005, 3, 1'b0);
    pulse(3, 20);
    chk("gl_error", 32'(bit_error), 32'h1);
    chk("gl_busy",  32'(busy),      32'h0);
    send_bits(24'hffffff, 24, 1'b0);
    send_bits(24'h000000, 2, 1'b0);
    idle(1600);
    chk("gl_ignored", 32'(n_valid - nv0), 32'd0);
    send_bits(24'h123456, 24, 1'b0);
    idle(20);
    chk("gl_count", 32'(n_valid - nv0), 32'd1);
    chk("gl_data",  32'(last_data),     32'h123456);
    chk("gl_index", 32'(last_index),    32'd1);

    // Partial word (10 bits) timed out by a long low
    do_reset();
    nv0 = n_valid;
    send_bits(24'h0000ff, 24, 1'b1);
    idle(40);
    send_bits(24'h0002aa, 10, 1'b0);
    chk("pw_busy1",  32'(busy),      32'h1);
    chk("pw_error0", 32'(bit_error), 32'h0);
    idle(1600);
    chk("pw_error1", 32'(bit_error),     32'h1);
    chk("pw_busy0",  32'(busy),          32'h0);
    chk("pw_novalid",32'(n_valid - nv0), 32'd1);
    send_bits(24'h654321, 24, 1'b0);
    idle(20);
    chk("pw_data",  32'(last_data),  32'h654321);
    chk("pw_index", 32'(last_index), 32'd1);

    // Overlong high pulse
    do_reset();
    nv0 = n_valid;
    din = 1'b1;
    repeat (45) @(negedge clk);
    chk("lh_error0", 32'(bit_error), 32'h0);
    chk("lh_busy1",  32'(busy),      32'h1);
    repeat (15) @(negedge clk);
    chk("lh_error1", 32'(bit_error), 32'h1);
    chk("lh_busy0",  32'(busy),      32'h0);
    idle(1600);
    chk("lh_novalid", 32'(n_valid - nv0), 32'd0);
    send_bits(24'hc0ffee, 24, 1'b0);
    idle(20);
    chk("lh_data",  32'(last_data),  32'hc0ffee);
    chk("lh_index", 32'(last_index), 32'd0);

    // Reset mid-word clears everything including the sticky error
    send_bits(24'h000fff, 12, 1'b0);
    chk("mr_busy1", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_data",  32'(pixel_data),  32'h0);
    chk("mr_index", 32'(pixel_index), 32'h0);
    chk("mr_error", 32'(bit_error),   32'h0);
    chk("mr_busy",  32'(busy),        32'h0);
    chk("mr_valid", 32'(pixel_valid), 32'h0);
    reset = 1'b0;
    idle(5);
    nv0 = n_valid;
    send_bits(24'ha5c33c, 24, 1'b0);
    idle(20);
    chk("mr_count",  32'(n_valid - nv0), 32'd1);
    chk("mr_wdata",  32'(last_data),     32'ha5c33c);
    chk("mr_windex", 32'(last_index),    32'd0);
    chk("mr_werror", 32'(bit_error),     32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
